// File: rtl/lfsr_decrypter.sv
// Recovers a 6-bit LFSR seed/tap from a plaintext-space preamble and decrypts a message in dat_mem.
// Optional: define LFSR_DECRYPTER_CYCLE_CNT_EN to add a saturating 16-bit busy-cycle counter output.
module lfsr_decrypter #(
  parameter int W        = 8,
  parameter int AW       = 8,
  parameter int SRC_BASE = 64,
  parameter int DST_BASE = 0,
  parameter int MSG_LEN  = 64,
  parameter int PRE_LEN  = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] raddr,
  input  logic [W-1:0]  rdata,
  output logic [AW-1:0] waddr,
  output logic [W-1:0]  wdata,
  output logic          write_en,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [2:0]    tap_sel
`ifdef LFSR_DECRYPTER_CYCLE_CNT_EN
  ,
  output logic [15:0]   cycles
`endif
);

  typedef enum logic [2:0] {IDLE, SEED, TEST, DECRYPT, DONE, FAIL} state_t;

  localparam logic [AW-1:0] SRC_C    = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_C    = AW'(DST_BASE);
  localparam logic [AW:0]   MSG_LAST = (AW+1)'(MSG_LEN - 1);
  localparam logic [AW:0]   PRE_LAST = (AW+1)'(PRE_LEN - 1);

  function automatic logic [5:0] tap_of(input logic [2:0] idx);
    case (idx)
      3'd0:    return 6'h21;
      3'd1:    return 6'h2D;
      3'd2:    return 6'h30;
      3'd3:    return 6'h33;
      3'd4:    return 6'h36;
      default: return 6'h39;
    endcase
  endfunction

  function automatic logic [5:0] lfsr_next(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  state_t        state, state_n;
  logic [AW:0]   i, i_n;
  logic [2:0]    tap_idx, tap_idx_n;
  logic [2:0]    tap_sel_n;
  logic [5:0]    lfsr, lfsr_n;
  logic [5:0]    seed, seed_n;
  logic [5:0]    key;

  // Keystream value implied by a plaintext space at the current read address.
  assign key = rdata[5:0] ^ 6'h20;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      i       <= '0;
      tap_idx <= '0;
      tap_sel <= '0;
      lfsr    <= '0;
      seed    <= '0;
    end else begin
      state   <= state_n;
      i       <= i_n;
      tap_idx <= tap_idx_n;
      tap_sel <= tap_sel_n;
      lfsr    <= lfsr_n;
      seed    <= seed_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    i_n       = i;
    tap_idx_n = tap_idx;
    tap_sel_n = tap_sel;
    lfsr_n    = lfsr;
    seed_n    = seed;
    write_en  = 1'b0;
    wdata     = '0;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_n = SEED;
          i_n     = '0;
        end
      end
      SEED: begin
        seed_n    = key;
        lfsr_n    = lfsr_next(key, tap_of(3'd0));
        tap_idx_n = '0;
        i_n       = (AW+1)'(1);
        state_n   = TEST;
      end
      TEST: begin
        if (key == lfsr) begin
          if (i == PRE_LAST) begin
            tap_sel_n = tap_idx;
            lfsr_n    = seed;
            i_n       = '0;
            state_n   = DECRYPT;
          end else begin
            i_n    = i + 1'b1;
            lfsr_n = lfsr_next(lfsr, tap_of(tap_idx));
          end
        end else if (tap_idx < 3'd5) begin
          // Restart the preamble check from byte 1 with the next candidate tap.
          tap_idx_n = tap_idx + 3'd1;
          i_n       = (AW+1)'(1);
          lfsr_n    = lfsr_next(seed, tap_of(tap_idx + 3'd1));
        end else begin
          state_n = FAIL;
        end
      end
      DECRYPT: begin
        write_en = 1'b1;
        wdata    = rdata ^ {{(W-6){1'b0}}, lfsr};
        lfsr_n   = lfsr_next(lfsr, tap_of(tap_sel));
        if (i == MSG_LAST) state_n = DONE;
        else               i_n     = i + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy  = (state == SEED) || (state == TEST) || (state == DECRYPT);
  assign done  = (state == DONE);
  assign fail  = (state == FAIL);
  assign raddr = busy ? SRC_C + i[AW-1:0] : '0;
  assign waddr = (state == DECRYPT) ? DST_C + i[AW-1:0] : '0;

`ifdef LFSR_DECRYPTER_CYCLE_CNT_EN
  logic accept;
  assign accept = start && ((state == IDLE) || (state == DONE) || (state == FAIL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                cycles <= '0;
    else if (accept)                        cycles <= '0;
    else if (busy && (cycles != 16'hFFFF))  cycles <= cycles + 16'd1;
  end
`endif

endmodule
